// File: rtl/pipelined_fp_adder_hs.sv
// rtl/pipelined_fp_adder_hs.sv - 3-stage pipelined FP adder/subtractor with valid/ready handshake
// Word format: {exc[1:0], sign, exp, frac}; exc 00=zero, 01=normal, 10=inf, 11=NaN.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake (in_ready depends only on pipeline state and out_ready)
//   sub, rnd_mode, tag_i  1 = A-B; 00 RNE, 01 RZ, 10 +inf, 11 -inf; opaque tag
//   a_i, b_i              operands
//   out_valid / out_ready result handshake
//   result_o, tag_o       registered result and its tag
//   ovf_o, unf_o          result overflowed to inf / underflowed to zero
module pipelined_fp_adder_hs #(
  parameter int SIZE_MANTISSA = 24,
  parameter int SIZE_EXPONENT = 8,
  parameter int SIZE_EXC      = 2,
  parameter int SIZE_COUNTER  = 5,
  parameter int TAG_WIDTH     = 4,
  parameter int SIZE          = SIZE_EXC + 1 + SIZE_EXPONENT + SIZE_MANTISSA - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sub,
  input  logic [1:0]           rnd_mode,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic [SIZE-1:0]      a_i,
  input  logic [SIZE-1:0]      b_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE-1:0]      result_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic                 ovf_o,
  output logic                 unf_o
);
  localparam int M  = SIZE_MANTISSA;
  localparam int E  = SIZE_EXPONENT;
  localparam int F  = M - 1;
  localparam int C  = SIZE_COUNTER;
  localparam int W  = M + 3;          // significand + guard, round, sticky
  localparam int XW = E + 2;          // exponent with carry and sign room
  localparam logic [1:0]      EXC_ZERO = 2'b00;
  localparam logic [1:0]      EXC_NORM = 2'b01;
  localparam logic [1:0]      EXC_INF  = 2'b10;
  localparam logic [1:0]      EXC_NAN  = 2'b11;
  localparam logic [E-1:0]    SH_MAX   = E'(M + 2);
  localparam logic [XW-1:0]   EXP_MAX  = XW'((1 << E) - 1);
  localparam logic [SIZE-1:0] NAN_W    = {EXC_NAN, {(SIZE - SIZE_EXC){1'b0}}};

  function automatic logic [C-1:0] lzc(input logic [W-1:0] v);
    logic [C-1:0] n;
    n = C'(W);
    for (int i = 0; i < W; i++)
      if (v[i]) n = C'(W - 1 - i);
    return n;
  endfunction

  // ---------------- handshake ----------------
  logic s1_v, s2_v;
  logic ld1, ld2, ld3;
  assign ld3      = out_ready | ~out_valid;
  assign ld2      = ~s2_v | ld3;
  assign ld1      = ~s1_v | ld2;
  assign in_ready = ld1;

  // ---------------- stage 1: unpack, swap, align, special cases ----------------
  logic [1:0]     xa, xb;
  logic           sa, sb;
  logic [E-1:0]   ea, eb, l_e, s_e, dexp;
  logic [M-1:0]   ma, mb, l_m, s_m;
  logic           swap, l_s, eff_sub;
  logic [2*M+3:0] wide;
  logic [M+1:0]   al;
  logic           st;
  logic           spec;
  logic [SIZE-1:0] spec_w;

  assign xa      = a_i[SIZE-1 -: SIZE_EXC];
  assign xb      = b_i[SIZE-1 -: SIZE_EXC];
  assign sa      = a_i[SIZE-SIZE_EXC-1];
  assign sb      = b_i[SIZE-SIZE_EXC-1] ^ sub;   // subtraction folds into B's sign
  assign ea      = a_i[F +: E];
  assign eb      = b_i[F +: E];
  assign ma      = {1'b1, a_i[F-1:0]};
  assign mb      = {1'b1, b_i[F-1:0]};
  assign eff_sub = sa ^ sb;
  assign swap    = (eb > ea) || ((eb == ea) && (mb > ma));
  assign l_s     = swap ? sb : sa;
  assign l_e     = swap ? eb : ea;
  assign s_e     = swap ? ea : eb;
  assign l_m     = swap ? mb : ma;
  assign s_m     = swap ? ma : mb;
  assign dexp    = l_e - s_e;
  // Lower half catches every bit shifted past the round position for the sticky OR.
  assign wide    = {s_m, {(M + 4){1'b0}}} >> dexp;
  assign al      = (dexp >= SH_MAX) ? '0   : wide[2*M+3 : M+2];
  assign st      = (dexp >= SH_MAX) ? 1'b1 : |wide[M+1:0];

  always_comb begin
    spec   = 1'b1;
    spec_w = '0;
    if (xa == EXC_NAN || xb == EXC_NAN)
      spec_w = NAN_W;
    else if (xa == EXC_INF && xb == EXC_INF)
      spec_w = eff_sub ? NAN_W : {EXC_INF, sa, {(E + F){1'b0}}};
    else if (xa == EXC_INF)
      spec_w = {EXC_INF, sa, {(E + F){1'b0}}};
    else if (xb == EXC_INF)
      spec_w = {EXC_INF, sb, {(E + F){1'b0}}};
    else if (xa == EXC_ZERO && xb == EXC_ZERO)
      spec_w = '0;
    else if (xa == EXC_ZERO)
      spec_w = {xb, sb, b_i[E+F-1:0]};
    else if (xb == EXC_ZERO)
      spec_w = a_i;
    else
      spec = 1'b0;
  end

  logic                 s1_spec, s1_sign, s1_sub, s1_st;
  logic [SIZE-1:0]      s1_sw;
  logic [E-1:0]         s1_e;
  logic [M-1:0]         s1_m;
  logic [M+1:0]         s1_al;
  logic [1:0]           s1_rnd;
  logic [TAG_WIDTH-1:0] s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_v <= 1'b0;
    else if (ld1) s1_v <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      s1_spec <= spec;
      s1_sw   <= spec_w;
      s1_sign <= l_s;
      s1_sub  <= eff_sub;
      s1_e    <= l_e;
      s1_m    <= l_m;
      s1_al   <= al;
      s1_st   <= st;
      s1_rnd  <= rnd_mode;
      s1_tag  <= tag_i;
    end
  end

  // ---------------- stage 2: add/sub, normalise ----------------
  logic [W-1:0]  lx, sx, n_norm;
  logic [W:0]    sum;
  logic [C-1:0]  lz;
  logic [XW-1:0] n_exp;

  assign lx  = {s1_m, 3'b000};
  assign sx  = {s1_al, s1_st};
  assign sum = s1_sub ? ({1'b0, lx} - {1'b0, sx}) : ({1'b0, lx} + {1'b0, sx});
  assign lz  = lzc(sum[W-1:0]);

  always_comb begin
    n_norm = '0;
    n_exp  = '0;
    if (sum[W]) begin
      // carry out: one-bit right shift, dropped bit joins sticky
      n_norm = {sum[W:2], sum[1] | sum[0]};
      n_exp  = {2'b00, s1_e} + XW'(1);
    end else begin
      n_norm = sum[W-1:0] << lz;
      n_exp  = {2'b00, s1_e} - {{(XW - C){1'b0}}, lz};
    end
  end

  logic                 s2_spec, s2_sign, s2_zero;
  logic [SIZE-1:0]      s2_sw;
  logic [W-1:0]         s2_norm;
  logic [XW-1:0]        s2_exp;
  logic [1:0]           s2_rnd;
  logic [TAG_WIDTH-1:0] s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_v <= 1'b0;
    else if (ld2) s2_v <= s1_v;
  end

  always_ff @(posedge clk) begin
    if (ld2 && s1_v) begin
      s2_spec <= s1_spec;
      s2_sw   <= s1_sw;
      s2_sign <= s1_sign;
      s2_zero <= (sum == '0);
      s2_norm <= n_norm;
      s2_exp  <= n_exp;
      s2_rnd  <= s1_rnd;
      s2_tag  <= s1_tag;
    end
  end

  // ---------------- stage 3: round, exponent checks, pack ----------------
  logic            inexact, inc;
  logic [M:0]      mr;
  logic [XW-1:0]   fexp;
  logic [F-1:0]    ffrac;
  logic [SIZE-1:0] r_word;
  logic            r_ovf, r_unf;

  assign inexact = s2_norm[2] | s2_norm[1] | s2_norm[0];

  always_comb begin
    case (s2_rnd)
      2'b00:   inc = s2_norm[2] & (s2_norm[1] | s2_norm[0] | s2_norm[3]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = inexact & ~s2_sign;
      default: inc = inexact & s2_sign;
    endcase
  end

  always_comb begin
    mr    = {1'b0, s2_norm[W-1:3]} + {{M{1'b0}}, inc};
    fexp  = s2_exp;
    ffrac = mr[F-1:0];
    if (mr[M]) begin
      // rounding carried into a new leading bit
      fexp  = s2_exp + XW'(1);
      ffrac = mr[F:1];
    end
  end

  always_comb begin
    r_word = '0;
    r_ovf  = 1'b0;
    r_unf  = 1'b0;
    if (s2_spec)
      r_word = s2_sw;
    else if (s2_zero)
      r_word = {EXC_ZERO, (s2_rnd == 2'b11), {(E + F){1'b0}}};
    else if ($signed(fexp) > $signed(EXP_MAX)) begin
      r_word = {EXC_INF, s2_sign, {(E + F){1'b0}}};
      r_ovf  = 1'b1;
    end else if (fexp[XW-1])
      r_unf  = 1'b1;
    else
      r_word = {EXC_NORM, s2_sign, fexp[E-1:0], ffrac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result_o  <= '0;
      tag_o     <= '0;
      ovf_o     <= 1'b0;
      unf_o     <= 1'b0;
    end else if (ld3) begin
      out_valid <= s2_v;
      if (s2_v) begin
        result_o <= r_word;
        tag_o    <= s2_tag;
        ovf_o    <= r_ovf;
        unf_o    <= r_unf;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_fp_adder_hs.sv
// tb/tb_pipelined_fp_adder_hs.sv - self-checking bench for pipelined_fp_adder_hs
module tb_pipelined_fp_adder_hs;
  localparam int SZ = 34;
  localparam int TW = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready, sub = 1'b0;
  logic [1:0]    rnd_mode = 2'b00;
  logic [TW-1:0] tag_i = '0, tag_o;
  logic [SZ-1:0] a_i = '0, b_i = '0, result_o;
  logic          out_valid, out_ready = 1'b1, ovf_o, unf_o;

  always #5 clk = ~clk;

  pipelined_fp_adder_hs dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sub(sub), .rnd_mode(rnd_mode), .tag_i(tag_i), .a_i(a_i), .b_i(b_i),
    .out_valid(out_valid), .out_ready(out_ready), .result_o(result_o),
    .tag_o(tag_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  typedef struct {
    logic [SZ-1:0] a, b;
    logic          sub;
    logic [1:0]    rnd;
    logic [SZ-1:0] res;
    logic          ovf, unf;
  } vec_t;

  typedef struct {
    logic [SZ-1:0] res;
    logic          ovf, unf;
    logic [TW-1:0] tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   tests = 0, fails = 0;
  bit   rand_ready = 0;

  function automatic logic [SZ-1:0] fp(input logic [1:0] x, input logic s,
                                       input logic [7:0] e, input logic [22:0] f);
    return {x, s, e, f};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic add(input logic [SZ-1:0] a, input logic [SZ-1:0] b, input logic s,
                     input logic [1:0] r, input logic [SZ-1:0] res, input logic o, input logic u);
    vecs.push_back('{a, b, s, r, res, o, u});
  endtask

  task automatic send(input vec_t v, input logic [TW-1:0] tag);
    bit acc;
    acc = 0;
    in_valid = 1'b1; a_i = v.a; b_i = v.b; sub = v.sub; rnd_mode = v.rnd; tag_i = tag;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      else begin @(posedge clk); #1; end
    end
    if (acc) sb_q.push_back('{v.res, v.ovf, v.unf, tag});
    else check("accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin @(posedge clk); n++; end
    check("drain_empty", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // scoreboard monitor and stall-stability check
  bit            stall_q = 0;
  logic [SZ-1:0] res_q;
  logic [TW-1:0] tag_q;
  exp_t          mon_e;
  initial forever begin
    @(negedge clk);
    if (!rst_n) stall_q = 0;
    else begin
      if (stall_q) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_result", result_o, res_q);
        check("stall_tag", tag_o, tag_q);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("unexpected_output", {63'd0, out_valid}, 64'd0);
        else begin
          mon_e = sb_q.pop_front();
          check("result", result_o, mon_e.res);
          check("ovf", {63'd0, ovf_o}, {63'd0, mon_e.ovf});
          check("unf", {63'd0, unf_o}, {63'd0, mon_e.unf});
          check("tag", tag_o, mon_e.tag);
        end
      end
      stall_q = out_valid && !out_ready;
      res_q   = result_o;
      tag_q   = tag_o;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_low;
    int lat;
    bit seen;
    logic [SZ-1:0] one_w, two_w, inf_w, ninf_w, nan_w, zero_w, b_tie, b_half;
    one_w  = fp(2'd1, 1'b0, 8'h7F, 23'h0);
    two_w  = fp(2'd1, 1'b0, 8'h80, 23'h0);
    inf_w  = fp(2'd2, 1'b0, 8'h00, 23'h0);
    ninf_w = fp(2'd2, 1'b1, 8'h00, 23'h0);
    nan_w  = fp(2'd3, 1'b0, 8'h00, 23'h0);
    zero_w = '0;
    b_tie  = fp(2'd1, 1'b0, 8'h68, 23'h400000);
    b_half = fp(2'd1, 1'b0, 8'h67, 23'h0);

    add(one_w, one_w, 0, 2'b00, two_w, 0, 0);
    add(one_w, one_w, 1, 2'b00, zero_w, 0, 0);
    add(one_w, one_w, 1, 2'b11, fp(2'd0, 1'b1, 8'h00, 23'h0), 0, 0);
    add(one_w, b_tie, 0, 2'b00, fp(2'd1, 1'b0, 8'h7F, 23'h2), 0, 0);
    add(one_w, b_tie, 0, 2'b01, fp(2'd1, 1'b0, 8'h7F, 23'h1), 0, 0);
    add(one_w, b_half, 0, 2'b00, one_w, 0, 0);
    add(one_w, b_half, 0, 2'b10, fp(2'd1, 1'b0, 8'h7F, 23'h1), 0, 0);
    add(fp(2'd1, 1'b1, 8'h7F, 23'h0), fp(2'd1, 1'b1, 8'h67, 23'h0), 0, 2'b11,
        fp(2'd1, 1'b1, 8'h7F, 23'h1), 0, 0);
    add(fp(2'd1, 1'b0, 8'hFF, 23'h7FFFFF), fp(2'd1, 1'b0, 8'hFF, 23'h7FFFFF), 0, 2'b00, inf_w, 1, 0);
    add(inf_w, inf_w, 1, 2'b00, nan_w, 0, 0);
    add(inf_w, one_w, 0, 2'b00, inf_w, 0, 0);
    add(one_w, inf_w, 1, 2'b00, ninf_w, 0, 0);
    add(zero_w, fp(2'd1, 1'b0, 8'h7F, 23'h400000), 1, 2'b00, fp(2'd1, 1'b1, 8'h7F, 23'h400000), 0, 0);
    add(nan_w, one_w, 0, 2'b00, nan_w, 0, 0);
    add(two_w, fp(2'd1, 1'b0, 8'h7F, 23'h400000), 1, 2'b00, fp(2'd1, 1'b0, 8'h7E, 23'h0), 0, 0);
    add(fp(2'd1, 1'b0, 8'h7F, 23'h400000), fp(2'd1, 1'b0, 8'h80, 23'h400000), 0, 2'b00,
        fp(2'd1, 1'b0, 8'h81, 23'h100000), 0, 0);
    add(fp(2'd1, 1'b0, 8'h01, 23'h0), fp(2'd1, 1'b0, 8'h00, 23'h7FFFFF), 1, 2'b00, zero_w, 0, 1);
    add(one_w, fp(2'd1, 1'b1, 8'h7F, 23'h0), 0, 2'b00, zero_w, 0, 0);
    add(zero_w, zero_w, 1, 2'b00, zero_w, 0, 0);
    add(fp(2'd1, 1'b1, 8'h85, 23'h123456), zero_w, 1, 2'b01, fp(2'd1, 1'b1, 8'h85, 23'h123456), 0, 0);

    // reset state
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_tag", tag_o, 64'd0);
    check("rst_ovf", {63'd0, ovf_o}, 64'd0);
    check("rst_unf", {63'd0, unf_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // table pass, back to back
    foreach (vecs[i]) send(vecs[i], TW'(i));
    drain();

    // table pass, random consumer stalls
    rand_ready = 1;
    foreach (vecs[i]) send(vecs[i], TW'(i + 3));
    drain();
    rand_ready = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // backpressure: 8 ops, consumer stalls for 5 cycles
    saw_low = 0;
    fork
      begin for (int i = 0; i < 8; i++) send(vecs[i], TW'(i)); end
      begin repeat (3) @(posedge clk); #1; out_ready = 1'b0; repeat (5) @(posedge clk); #1; out_ready = 1'b1; end
      begin repeat (14) begin @(negedge clk); if (!in_ready) saw_low = 1; end end
    join
    check("in_ready_backpressure", {63'd0, saw_low}, 64'd0 | (saw_low ? 64'd1 : 64'd1));
    check("in_ready_went_low", {63'd0, saw_low}, 64'd1);
    drain();

    // reset with operations in flight
    for (int i = 0; i < 3; i++) send(vecs[i], TW'(i));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    sb_q.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_stale_after_rst", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    send(vecs[3], 4'hA);
    lat = 1;
    seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else begin @(posedge clk); lat++; end
    end
    check("latency_after_rst", lat, 3);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
